bbox_downsampler: RTL and testbench

//  Downstream of boundingBox: on start, latches bounding box (xMin..yMax), resamples that region of the
//  24-bit BMP in memory to a fixed OUT_W x OUT_H 8-bit grayscale grid (nearest neighbour) and writes it
//  to the classifier input buffer. Start/done handshake matches the bounding-box stage so the two chain directly.

---
 rtl/bbox_pkg.sv | 28 ++
 rtl/seq_divider.sv | 70 +++++++
 rtl/bbox_downsampler.sv | 203 ++++++++++++++++++++
 tb/tb_bbox_downsampler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box pipeline stages.
package bbox_pkg;

  localparam int COORD_W = 11;
  localparam logic [7:0] BG_LEVEL = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    DIV_X,
    DIV_Y,
    RD0,
    RD1,
    RD2,
    RD3,
    WR,
    FILL,
    FINISHED
  } state_t;

  // Luma approximation (R + 2G + B) / 4 on a 10-bit sum, truncated.
  function automatic logic [7:0] gray(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider: one load cycle (which also resolves the quotient MSB) plus NUM_W-1 iterate
// cycles. done is high during the last iterate cycle, with quo valid in that same cycle.
module seq_divider #(
  parameter int NUM_W = 20,
  parameter int DEN_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             done,
  output logic [NUM_W-1:0] quo
);

  localparam int CNT_W = $clog2(NUM_W);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [NUM_W-1:0] num_q;
  logic [NUM_W-2:0] quo_q;
  logic [DEN_W-1:0] den_q;
  logic [DEN_W-1:0] rem_q;

  logic [DEN_W:0]   rem_sh;
  logic [DEN_W:0]   diff;
  logic [DEN_W-1:0] rem_nx;
  logic             fits;

  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    rem_sh = '0;
    if (busy) rem_sh = {rem_q, num_q[NUM_W-1]};
    else      rem_sh = {{DEN_W{1'b0}}, num[NUM_W-1]};
    diff   = rem_sh - {1'b0, (busy ? den_q : den)};
    fits   = (rem_sh >= {1'b0, (busy ? den_q : den)});
    rem_nx = fits ? diff[DEN_W-1:0] : rem_sh[DEN_W-1:0];
  end

  assign done = busy && (cnt == '0);
  assign quo  = {quo_q, fits};

  // NOTE: sequential state uses <= so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      num_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      rem_q <= '0;
    end else if (!busy) begin
      if (start) begin
        busy  <= 1'b1;
        cnt   <= CNT_W'(NUM_W - 2);
        num_q <= num << 1;
        den_q <= den;
        rem_q <= rem_nx;
        quo_q <= {{(NUM_W-2){1'b0}}, fits};
      end
    end else begin
      num_q <= num_q << 1;
      rem_q <= rem_nx;
      quo_q <= {quo_q[NUM_W-3:0], fits};
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/bbox_downsampler.sv
// Resamples a latched bounding box of a bottom-up 24-bit BMP into an OUT_W x OUT_H grayscale grid
// (nearest neighbour), writing one output sample per 5 cycles; empty boxes fill with background.
module bbox_downsampler
  import bbox_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int OUT_W  = 28,
  parameter int OUT_H  = 28,
  parameter int FRAC   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            done,
  output logic                            empty,
  input  logic [COORD_W-1:0]              xMin,
  input  logic [COORD_W-1:0]              xMax,
  input  logic [COORD_W-1:0]              yMin,
  input  logic [COORD_W-1:0]              yMax,
  output logic [31:0]                     addr,
  input  logic [15:0]                     rddata,
  output logic                            out_we,
  output logic [$clog2(OUT_W*OUT_H)-1:0]  out_addr,
  output logic [7:0]                      out_data
);

  localparam int PIX_N = OUT_W * OUT_H;
  localparam int OA_W  = $clog2(PIX_N);
  localparam int COL_W = $clog2(OUT_W);
  localparam int DIM_W = COORD_W + 1;
  localparam int ACC_W = DIM_W + FRAC;

  state_t             state;
  logic [COORD_W-1:0] x_min, x_max, y_min, y_max;
  logic [ACC_W-1:0]   step_x, step_y, acc_x, acc_y;
  logic [COL_W-1:0]   col;
  logic [OA_W-1:0]    pix;
  logic [7:0]         byte0, byte1;
  logic               div_start;

  logic [DIM_W-1:0]   span_x, span_y;
  logic [ACC_W-1:0]   div_num, div_quo;
  logic [DIM_W-1:0]   div_den;
  logic               div_done;
  logic               row_end, last_pix;
  logic [ACC_W-1:0]   acc_x_nx, acc_y_nx;
  logic [31:0]        sx, sy, next_base;
  logic               unused_hi;

  assign unused_hi = ^rddata[15:8];

  assign span_x  = {1'b0, x_max} - {1'b0, x_min} + DIM_W'(1);
  assign span_y  = {1'b0, y_max} - {1'b0, y_min} + DIM_W'(1);
  assign div_num = (state == DIV_Y) ? (ACC_W'(span_y) << FRAC) : (ACC_W'(span_x) << FRAC);
  assign div_den = (state == DIV_Y) ? DIM_W'(OUT_H) : DIM_W'(OUT_W);

  seq_divider #(
    .NUM_W (ACC_W),
    .DEN_W (DIM_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .num   (div_num),
    .den   (div_den),
    .done  (div_done),
    .quo   (div_quo)
  );

  assign row_end  = (col == COL_W'(OUT_W - 1));
  assign last_pix = (pix == OA_W'(PIX_N - 1));

  // Source address of the pixel about to be read: the next pixel when leaving WR, pixel 0 otherwise.
  always_comb begin
    acc_x_nx = '0;
    acc_y_nx = '0;
    if (state == WR) begin
      if (row_end) begin
        acc_x_nx = '0;
        acc_y_nx = acc_y + step_y;
      end else begin
        acc_x_nx = acc_x + step_x;
        acc_y_nx = acc_y;
      end
    end
    sx        = 32'(x_min) + 32'(acc_x_nx >> FRAC);
    sy        = 32'(y_min) + 32'(acc_y_nx >> FRAC);
    next_base = (32'(HEIGHT) - sy - 32'd1) * 32'(WIDTH * 3) + sx * 32'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      empty     <= 1'b0;
      addr      <= '0;
      out_we    <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      x_min     <= '0;
      x_max     <= '0;
      y_min     <= '0;
      y_max     <= '0;
      step_x    <= '0;
      step_y    <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      col       <= '0;
      pix       <= '0;
      byte0     <= '0;
      byte1     <= '0;
      div_start <= 1'b0;
    end else begin
      div_start <= 1'b0;
      case (state)
        IDLE, FINISHED: begin
          if (start) begin
            x_min <= xMin;
            x_max <= xMax;
            y_min <= yMin;
            y_max <= yMax;
            done  <= 1'b0;
            empty <= 1'b0;
            acc_x <= '0;
            acc_y <= '0;
            col   <= '0;
            pix   <= '0;
            if ((xMax < xMin) || (yMax < yMin)) begin
              state    <= FILL;
              out_we   <= 1'b1;
              out_addr <= '0;
              out_data <= BG_LEVEL;
            end else begin
              state     <= DIV_X;
              div_start <= 1'b1;
            end
          end
        end
        DIV_X: begin
          if (div_done) begin
            step_x    <= div_quo;
            div_start <= 1'b1;
            state     <= DIV_Y;
          end
        end
        DIV_Y: begin
          if (div_done) begin
            step_y <= div_quo;
            addr   <= next_base;
            state  <= RD0;
          end
        end
        RD0: begin
          addr  <= addr + 32'd1;
          state <= RD1;
        end
        RD1: begin
          byte0 <= rddata[7:0];
          addr  <= addr + 32'd1;
          state <= RD2;
        end
        RD2: begin
          byte1 <= rddata[7:0];
          state <= RD3;
        end
        // Third byte goes straight from the bus into the sum; it is never stored.
        RD3: begin
          out_we   <= 1'b1;
          out_data <= gray(byte0, byte1, rddata[7:0]);
          out_addr <= pix;
          state    <= WR;
        end
        WR: begin
          out_we <= 1'b0;
          acc_x  <= acc_x_nx;
          acc_y  <= acc_y_nx;
          col    <= row_end ? '0 : col + COL_W'(1);
          if (last_pix) begin
            done  <= 1'b1;
            state <= FINISHED;
          end else begin
            pix   <= pix + OA_W'(1);
            addr  <= next_base;
            state <= RD0;
          end
        end
        FILL: begin
          if (out_addr == OA_W'(PIX_N - 1)) begin
            out_we <= 1'b0;
            empty  <= 1'b1;
            done   <= 1'b1;
            state  <= FINISHED;
          end else begin
            out_addr <= out_addr + OA_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_downsampler.sv
// Directed bench for bbox_downsampler: a frame-level model predicts every output sample.
module tb_bbox_downsampler;

  localparam int WIDTH  = 100;
  localparam int HEIGHT = 100;
  localparam int OUT_W  = 28;
  localparam int OUT_H  = 28;
  localparam int PIX_N  = OUT_W * OUT_H;
  localparam int MEM_N  = WIDTH * HEIGHT * 3;
  localparam int RUN_LAT  = 1 + 40 + 5 * PIX_N;
  localparam int FILL_LAT = 1 + PIX_N;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        done, empty;
  logic [10:0] xMin, xMax, yMin, yMax;
  logic [31:0] addr;
  logic [15:0] rddata;
  logic        out_we;
  logic [9:0]  out_addr;
  logic [7:0]  out_data;

  logic [7:0]  mem [0:MEM_N-1];
  logic [7:0]  exp_img [0:PIX_N-1];
  logic [7:0]  hi_byte;

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_total = 0;
  int          wr_base = 0;
  int          log_base = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] addr_log [$];

  bbox_downsampler #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .OUT_W  (OUT_W),
    .OUT_H  (OUT_H),
    .FRAC   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .done     (done),
    .empty    (empty),
    .xMin     (xMin),
    .xMax     (xMax),
    .yMin     (yMin),
    .yMax     (yMax),
    .addr     (addr),
    .rddata   (rddata),
    .out_we   (out_we),
    .out_addr (out_addr),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  // Source memory: data for an address appears one cycle after it is presented.
  always @(posedge clk)
    rddata <= {hi_byte, (addr < 32'(MEM_N)) ? mem[addr] : 8'h00};

  task automatic check(input bit ok, input string name, input longint got, input longint want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Frame model: sample positions from integer step times index, then the luma formula.
  function automatic void build_model(input int x0, input int x1, input int y0, input int y1);
    int stx, sty, sx, sy, base;
    if (x1 < x0 || y1 < y0) begin
      for (int i = 0; i < PIX_N; i++) exp_img[i] = 8'hFF;
      return;
    end
    stx = ((x1 - x0 + 1) * 256) / OUT_W;
    sty = ((y1 - y0 + 1) * 256) / OUT_H;
    for (int r = 0; r < OUT_H; r++) begin
      for (int c = 0; c < OUT_W; c++) begin
        sx   = x0 + (c * stx) / 256;
        sy   = y0 + (r * sty) / 256;
        base = (HEIGHT - 1 - sy) * WIDTH * 3 + sx * 3;
        exp_img[r * OUT_W + c] =
          8'((int'(mem[base]) + 2 * int'(mem[base + 1]) + int'(mem[base + 2])) / 4);
      end
    end
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < MEM_N; i++) begin
      case (mode)
        0:       mem[i] = 8'h00;
        1:       mem[i] = 8'hFF;
        default: mem[i] = 8'((i * 37) ^ (i >> 5) ^ 8'h5A);
      endcase
    end
  endtask

  function automatic longint log_at(input int i);
    if (log_base + i < addr_log.size()) return longint'(addr_log[log_base + i]);
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check(done == 1'b0,     {tag, " done"},     done, 0);
    check(empty == 1'b0,    {tag, " empty"},    empty, 0);
    check(out_we == 1'b0,   {tag, " out_we"},   out_we, 0);
    check(out_addr == '0,   {tag, " out_addr"}, out_addr, 0);
    check(out_data == 8'h0, {tag, " out_data"}, out_data, 0);
    check(addr == 32'h0,    {tag, " addr"},     addr, 0);
  endtask

  // Called just after a negedge; returns at the negedge after the start-sampling edge.
  task automatic launch(input int x0, input int x1, input int y0, input int y1);
    build_model(x0, x1, y0, y1);
    wr_base  = wr_total;
    log_base = addr_log.size();
    xMin  = 11'(x0);
    xMax  = 11'(x1);
    yMin  = 11'(y0);
    yMax  = 11'(y1);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check(done == 1'b0,  "done after start",  done, 0);
    check(empty == 1'b0, "empty after start", empty, 0);
  endtask

  task automatic wait_done(input int exp_lat, input int pulse_every, input string tag);
    int cyc = 1;
    while (!done && cyc < 5000) begin
      start = (pulse_every != 0) && (cyc % pulse_every == 0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    check(cyc == exp_lat, {tag, " latency"}, cyc, exp_lat);
    repeat (3) @(negedge clk);
    check(done == 1'b1, {tag, " done held"}, done, 1);
    check(wr_total - wr_base == PIX_N, {tag, " write count"}, wr_total - wr_base, PIX_N);
  endtask

  // Compare process: every output strobe against the model, in ascending order.
  initial begin : compare
    int idx;
    forever begin
      @(negedge clk);
      if (rst_n && out_we) begin
        idx = wr_total - wr_base;
        check(idx < PIX_N, "write index range", idx, PIX_N - 1);
        if (idx < PIX_N) begin
          check(int'(out_addr) == idx, "out_addr", out_addr, idx);
          check(out_data == exp_img[idx], "out_data", out_data, exp_img[idx]);
        end
        wr_total++;
      end
      if (addr != last_addr) begin
        addr_log.push_back(addr);
        last_addr = addr;
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    xMin    = '0;
    xMax    = '0;
    yMin    = '0;
    yMax    = '0;
    hi_byte = 8'h00;
    fill_mem(0);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full frame of zeros; first pixel bases follow sx = 0, 3, 7, 10 on bottom BMP row.
    launch(0, 99, 0, 99);
    wait_done(RUN_LAT, 0, "full box");
    check(out_data == 8'h00, "full box last sample", out_data, 8'h00);
    check(log_at(0) == 29700, "first source addr", log_at(0), 29700);
    check(log_at(1) == 29701, "first addr +1", log_at(1), 29701);
    check(log_at(3) == 29709, "pixel 1 addr", log_at(3), 29709);
    check(log_at(6) == 29721, "pixel 2 addr", log_at(6), 29721);
    check(log_at(9) == 29730, "pixel 3 addr", log_at(9), 29730);

    // Single-pixel box at (40,40) on a white frame.
    fill_mem(1);
    mem[17820] = 8'h10;
    mem[17821] = 8'h20;
    mem[17822] = 8'h30;
    launch(40, 40, 40, 40);
    wait_done(RUN_LAT, 0, "one pixel");
    check(out_data == 8'h20, "one pixel sample", out_data, 8'h20);
    check(empty == 1'b0, "one pixel empty", empty, 0);

    // Empty box: background fill, no source reads.
    launch(99, 0, 0, 99);
    wait_done(FILL_LAT, 0, "empty box");
    check(empty == 1'b1, "empty flag", empty, 1);
    check(out_data == 8'hFF, "fill level", out_data, 8'hFF);
    check(addr_log.size() - log_base == 0, "reads on empty box", addr_log.size() - log_base, 0);

    // Upper data byte must not leak into the result.
    hi_byte = 8'hAB;
    launch(40, 40, 40, 40);
    wait_done(RUN_LAT, 0, "upper byte");
    check(out_data == 8'h20, "upper byte sample", out_data, 8'h20);
    hi_byte = 8'h00;

    // Reset during RD2 of pixel 100, then a clean run on a textured frame.
    fill_mem(2);
    launch(0, 99, 0, 99);
    repeat (542) @(posedge clk);
    @(negedge clk);
    check(wr_total - wr_base == 100, "writes before abort", wr_total - wr_base, 100);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid-run reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(10, 69, 20, 44);
    wait_done(RUN_LAT, 0, "after reset");

    // Start pulses while busy are ignored; restart from FINISHED reruns identically.
    launch(5, 90, 0, 60);
    wait_done(RUN_LAT, 97, "mid-run start");
    launch(5, 90, 0, 60);
    wait_done(RUN_LAT, 0, "rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
